// File: rtl/fp32_adder.sv
// Three-stage binary32 adder behind an operand register: unpack/align, add, normalize/round.
// Flush-to-zero on inputs and outputs, round-to-nearest-even, canonical quiet NaN.
module fp32_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] sum
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic        valid;
    logic        special;
    logic [31:0] spec_val;
    logic        sign;
    logic        sub;
    logic [7:0]  exp;
    logic [26:0] mx;
    logic [26:0] my;
  } s1_t;

  typedef struct packed {
    logic        valid;
    logic        special;
    logic [31:0] spec_val;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mag;
  } s2_t;

  logic        in_v;
  logic [31:0] a_q, b_q;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;

  logic [7:0]  ea, eb, d;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        swap, lost;
  logic [23:0] mx, my;
  logic [26:0] yfull, ysh;

  always_comb begin
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    fa     = a_q[22:0];
    fb     = b_q[22:0];
    a_nan  = (ea == 8'hFF) && (fa != '0);
    b_nan  = (eb == 8'hFF) && (fb != '0);
    a_inf  = (ea == 8'hFF) && (fa == '0);
    b_inf  = (eb == 8'hFF) && (fb == '0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    swap   = {eb, fb} > {ea, fa};
    mx     = swap ? {1'b1, fb} : {1'b1, fa};
    my     = swap ? {1'b1, fa} : {1'b1, fb};
    d      = swap ? (eb - ea) : (ea - eb);
    yfull  = {my, 3'b000};
    ysh    = yfull >> d;
    lost   = |(yfull & ~({27{1'b1}} << d));

    s1_d          = '0;
    s1_d.valid    = in_v;
    s1_d.sign     = swap ? b_q[31] : a_q[31];
    s1_d.sub      = a_q[31] ^ b_q[31];
    s1_d.exp      = swap ? eb : ea;
    s1_d.mx       = {mx, 3'b000};
    s1_d.my       = (d >= 8'd27) ? 27'd1
                                 : {ysh[26:1], ysh[0] | lost};
    s1_d.special  = 1'b1;
    // Priority order matters: NaN beats inf, inf beats zero.
    if (a_nan || b_nan)
      s1_d.spec_val = QNAN;
    else if (a_inf && b_inf)
      s1_d.spec_val = s1_d.sub ? QNAN : a_q;
    else if (a_inf)
      s1_d.spec_val = a_q;
    else if (b_inf)
      s1_d.spec_val = b_q;
    else if (a_zero && b_zero)
      s1_d.spec_val = {a_q[31] & b_q[31], 31'h0};
    else if (b_zero)
      s1_d.spec_val = a_q;
    else if (a_zero)
      s1_d.spec_val = b_q;
    else
      s1_d.special  = 1'b0;
  end

  always_comb begin
    s2_d          = '0;
    s2_d.valid    = s1_q.valid;
    s2_d.special  = s1_q.special;
    s2_d.spec_val = s1_q.spec_val;
    s2_d.sign     = s1_q.sign;
    s2_d.exp      = s1_q.exp;
    s2_d.mag      = s1_q.sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                             : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});
  end

  logic [4:0]        lz;
  logic              found;
  logic [26:0]       m27;
  logic signed [9:0] e;
  logic [23:0]       mant;
  logic              g, rs, up;
  logic [24:0]       mr;
  logic [22:0]       frac;
  logic [31:0]       res;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && s2_q.mag[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end

    if (s2_q.mag[27]) begin
      m27 = {s2_q.mag[27:2], s2_q.mag[1] | s2_q.mag[0]};
      e   = $signed({2'b00, s2_q.exp}) + 10'sd1;
    end else begin
      m27 = s2_q.mag[26:0] << lz;
      e   = $signed({2'b00, s2_q.exp}) - $signed({5'b0, lz});
    end

    mant = m27[26:3];
    g    = m27[2];
    rs   = |m27[1:0];
    up   = g & (rs | mant[0]);
    mr   = {1'b0, mant} + {24'b0, up};
    if (mr[24]) e = e + 10'sd1;
    frac = mr[24] ? mr[23:1] : mr[22:0];

    if (s2_q.special)
      res = s2_q.spec_val;
    else if (s2_q.mag == '0)
      res = 32'h0;
    else if (e >= 10'sd255)
      res = {s2_q.sign, 8'hFF, 23'h0};
    else if (e <= 10'sd0)
      res = {s2_q.sign, 31'h0};
    else
      res = {s2_q.sign, e[7:0], frac};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_v      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
    end else begin
      in_v <= in_valid;
      if (in_valid) begin
        a_q <= a;
        b_q <= b;
      end
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      out_valid <= s2_q.valid;
      if (s2_q.valid) sum <= res;
    end
  end

endmodule

// File: tb/tb_fp32_adder.sv
// Scoreboard bench for fp32_adder: exact wide-integer reference model,
// directed corner cases, random traffic, reset checks and latency checks.
module tb_fp32_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic [31:0] sum;

  fp32_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .out_valid(out_valid), .sum(sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  logic rst_q;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  // Exact sum in units of 2^-149, then one rounding step to 24 bits.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic [7:0]   ex, ey;
    logic [22:0]  fx, fy;
    logic [287:0] vx, vy, s, rem, half;
    logic         sg, fnd;
    int           p, sh, e;
    logic [24:0]  m;
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    if ((ex == 8'hFF && fx != 0) || (ey == 8'hFF && fy != 0)) return 32'h7FC00000;
    if (ex == 8'hFF && ey == 8'hFF) return (x[31] != y[31]) ? 32'h7FC00000 : x;
    if (ex == 8'hFF) return x;
    if (ey == 8'hFF) return y;
    if (ex == 0 && ey == 0) return {x[31] & y[31], 31'h0};
    if (ey == 0) return x;
    if (ex == 0) return y;
    vx = 288'({1'b1, fx}) << (ex - 1);
    vy = 288'({1'b1, fy}) << (ey - 1);
    if (x[31] == y[31]) begin s = vx + vy; sg = x[31]; end
    else if (vx > vy)   begin s = vx - vy; sg = x[31]; end
    else if (vy > vx)   begin s = vy - vx; sg = y[31]; end
    else return 32'h0;
    p = 0; fnd = 1'b0;
    for (int i = 287; i >= 0; i--)
      if (!fnd && s[i]) begin p = i; fnd = 1'b1; end
    if (p < 23) return {sg, 31'h0};
    sh  = p - 23;
    m   = 25'(s >> sh);
    rem = s & ((288'd1 << sh) - 288'd1);
    if (sh > 0) begin
      half = 288'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 25'd1;
    end
    if (m[24]) begin m = m >> 1; p = p + 1; end
    e = p - 22;
    if (e >= 255) return {sg, 8'hFF, 23'h0};
    return {sg, 8'(e), m[22:0]};
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] want, input bit track);
    exp_t t;
    in_valid = 1'b1; a = x; b = y;
    if (track) begin
      t.val = want; t.cyc = cyc + 4; t.a = x; t.b = y;
      q.push_back(t);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t t;
    if (rst_q === 1'b0) begin
      compared++;
      if (out_valid !== 1'b0 || sum !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_state: out_valid=%b sum=%h, required 0/00000000", out_valid, sum);
      end
    end else if (out_valid === 1'b1) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_out: sum=%h at cycle %0d, required no output", sum, cyc);
      end else begin
        t = q.pop_front();
        if (sum !== t.val || cyc != t.cyc) begin
          mismatched++;
          $display("FAIL sum a=%h b=%h: got %h at cycle %0d, required %h at cycle %0d",
                   t.a, t.b, sum, cyc, t.val, t.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] rnd_pair_b(input logic [31:0] x);
    logic [31:0] r, s;
    int          sel, e;
    r   = $urandom;
    s   = $urandom;
    sel = $urandom_range(0, 9);
    e   = int'(x[30:23]) + $urandom_range(0, 50) - 25;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    if (sel < 5) return {r[31], 8'(e), s[22:0]};
    if (sel == 5) return x ^ 32'h8000_0000;
    if (sel == 6) return (x ^ 32'h8000_0000) ^ {29'h0, r[2:0]};
    if (sel == 7) begin
      case (r[2:0])
        3'd0: return 32'h7F800000;
        3'd1: return 32'hFF800000;
        3'd2: return 32'h7FC00001;
        3'd3: return 32'h00000000;
        3'd4: return 32'h80000000;
        3'd5: return {r[31], 8'h00, s[22:0]};
        default: return {r[31], 8'hFE, s[22:0]};
      endcase
    end
    return r;
  endfunction

  initial begin
    logic [31:0] x, y, r;
    int          n;

    rst_n = 1'b0;
    repeat (5) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
    end
    rst_n = 1'b1;

    issue(32'h40400000, 32'h40A00000, 32'h41000000, 1'b1);
    issue(32'h40A00000, 32'h40A00000, 32'h41200000, 1'b1);
    issue(32'h40A00000, 32'hC0400000, 32'h40000000, 1'b1);
    issue(32'h3F800000, 32'hBF800000, 32'h00000000, 1'b1);
    issue(32'h3F800000, 32'h33800000, 32'h3F800000, 1'b1);
    issue(32'h3F800001, 32'h33800000, 32'h3F800002, 1'b1);
    issue(32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
    issue(32'h00000000, 32'h00000000, 32'h00000000, 1'b1);
    issue(32'h80000000, 32'h80000000, 32'h80000000, 1'b1);
    issue(32'h00000001, 32'h00000000, 32'h00000000, 1'b1);
    issue(32'h80000000, 32'h00000000, 32'h00000000, 1'b1);
    issue(32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b1);
    issue(32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b1);
    idle(3);
    issue(32'hC1200000, 32'h3F800000, 32'hC1100000, 1'b1);
    idle(6);

    // Two operations killed by a one-cycle reset before they emerge.
    issue(32'h3F800000, 32'h3F800000, 32'h0, 1'b0);
    issue(32'h40000000, 32'h40000000, 32'h0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL flushed_op: out_valid=%b sum=%h, required out_valid 0", out_valid, sum);
      end
    end

    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      x = {r[31], 8'($urandom_range(1, 254)), r[22:0]};
      if (i % 17 == 0) x = $urandom;
      y = rnd_pair_b(x);
      if (r[30]) issue(x, y, ref_add(x, y), 1'b1);
      else       issue(y, x, ref_add(y, x), 1'b1);
      if (i % 23 == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
